sipo_frame_receiver: RTL and testbench
======================================

Name: sipo_frame_receiver

Overview:
- Serial-in/parallel-out frame receiver.
- Consumes the bit stream produced by the team's shift-register serializer.
- Detects a start bit, shifts in WIDTH data bits (LSB-first or MSB-first), checks the stop bit, then presents the word on a valid/ready output port.
- Sits at the receive end of the serial link, feeding downstream parallel logic.

Parameters:
- WIDTH, 4, number of data bits per frame (legal range 2..32).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- sin  input  1  serial data line; idles high
- sin_valid  input  1  bit strobe; sin is sampled only in cycles where sin_valid=1
- msb_first  input  1  1: first data bit is bit WIDTH-1; 0: first data bit is bit 0
- data_out  output  WIDTH  received word, held stable while data_valid=1
- data_valid  output  1  word available
- data_ready  input  1  consumer accepts the word when data_valid & data_ready
- busy  output  1  frame in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  sticky: a complete frame was dropped because the holding register was full

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, bit counter=0, shift register=0. Outputs: data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0.
- Reset mid-frame discards the partial word. Reset overrides every other event in the same cycle.
- All logic advances only on cycles with sin_valid=1, except the output handshake, which is evaluated every cycle.
- FSM states and transitions:
  - IDLE: sin_valid & sin=0 → DATA. Clear the bit counter; latch msb_first into an internal direction flag, held for the whole frame. sin=1 → remain in IDLE.
  - DATA: on each strobe, shift sin into the shift register.
    - Direction flag=0 (LSB-first): shreg <= {sin, shreg[WIDTH-1:1]}.
    - Direction flag=1 (MSB-first): shreg <= {shreg[WIDTH-2:0], sin}.
    - Increment the counter. The strobe with counter=WIDTH-1 → STOP (or PARITY if the optional feature is enabled).
  - STOP: on strobe, sin=1 → commit and go to IDLE; sin=0 → frame_err=1 for exactly one cycle, word discarded, go to IDLE.
- A new start bit is accepted on the first strobe after returning to IDLE; back-to-back frames carry no gap penalty.
- Commit rules:
  - Holding register free, i.e. data_valid=0, or data_valid=1 & data_ready=1 in the same cycle: data_out <= shreg and data_valid <= 1 on the edge that samples the stop bit. Latency is 1 cycle from the stop-bit strobe to visible data_valid.
  - Holding register full (data_valid=1 & data_ready=0): the new word is dropped, the old data_out is retained, and overrun is set to 1. overrun stays 1 until rst.
- Handshake: data_valid & data_ready with no commit that cycle → data_valid <= 0; data_out keeps its last value.
- busy = (state != IDLE). It is registered with the state.
- Changing msb_first mid-frame has no effect until the next start bit.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP. The bit sampled there is an even-parity bit: XOR of the WIDTH data bits and the parity bit must equal 0.
  - Adds output port parity_err (1 bit): a one-cycle pulse on the stop-bit strobe of a frame whose parity failed, with the word discarded.
  - If the stop bit is also 0, frame_err and parity_err both pulse.
  - Frame length is WIDTH+3 strobes.
- Not defined: no PARITY state, no parity_err port; frame length is WIDTH+2 strobes.

Test Plan:
1. WIDTH=4, msb_first=0, continuous strobes, sin sequence 0,1,0,1,1,1 → data_out=4'b1101, data_valid=1 one cycle after the stop strobe; busy=1 from the start strobe through the stop strobe.
2. Same bits with msb_first=1 → data_out=4'b1011. Then toggle msb_first mid-frame on a second frame 0,0,0,1,1,1 (latched MSB-first) → data_out=4'b0011.
3. Stop bit 0 (sequence 0,1,1,1,1,0) → frame_err high exactly 1 cycle, data_valid remains 0, FSM back in IDLE; the next good frame is received normally.
4. data_ready held 0; send two good frames, 4'hA then 4'h5 → data_out stays 4'hA, overrun=1. Then assert data_ready → data_valid drops, overrun stays 1 until rst.
5. data_ready=1 in the same cycle as the second frame's stop strobe → no overrun; data_out=4'h5, data_valid stays 1.
6. rst asserted after 2 data bits → busy=0, all outputs 0 next cycle; a subsequent full frame 0,0,1,1,0,1 (LSB-first) → data_out=4'b0110.

Source files
------------

// File: rtl/sipo_frame_receiver.sv
// Serial-in/parallel-out frame receiver.
// Frame format: start bit (0), WIDTH data bits, optional even-parity bit, stop bit (1).
// Bits are sampled only on cycles with sin_valid=1. A received word is presented on a
// valid/ready port and held in a single holding register.
// Optional feature: define SIPO_PARITY_EN to add a parity bit between the data bits and the
// stop bit, plus a parity_err output port.
module sipo_frame_receiver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             msb_first,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic            dir_msb;   // direction latched at the start bit, held for the whole frame

  logic [WIDTH-1:0] shreg_next;
  logic             hold_free;
  logic             word_good;

`ifdef SIPO_PARITY_EN
  logic par_acc;   // running XOR of the data bits
  logic par_bad;   // parity check result, captured when the parity bit is sampled
`endif

  // Next shift-register value for the current sin, in the latched direction.
  always_comb begin
    shreg_next = shreg;
    if (dir_msb) begin
      shreg_next = {shreg[WIDTH-2:0], sin};
    end else begin
      shreg_next = {sin, shreg[WIDTH-1:1]};
    end
  end

  // Holding register can take a word this cycle; a word is committable on a good stop bit.
  always_comb begin
    hold_free = !data_valid || data_ready;
`ifdef SIPO_PARITY_EN
    word_good = sin && !par_bad;
`else
    word_good = sin;
`endif
  end

  // Frame FSM with registered outputs; the output handshake runs every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      shreg      <= '0;
      dir_msb    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Consumer takes the word; a commit below in the same cycle overrides this.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (sin_valid) begin
        case (state)
          StIdle: begin
            if (!sin) begin
              state   <= StData;
              busy    <= 1'b1;
              cnt     <= '0;
              dir_msb <= msb_first;
`ifdef SIPO_PARITY_EN
              par_acc <= 1'b0;
`endif
            end
          end

          StData: begin
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
`ifdef SIPO_PARITY_EN
            par_acc <= par_acc ^ sin;
`endif
            if (cnt == LastBit) begin
`ifdef SIPO_PARITY_EN
              state <= StParity;
`else
              state <= StStop;
`endif
            end
          end

`ifdef SIPO_PARITY_EN
          StParity: begin
            // Even parity: data bits XOR parity bit must be 0.
            par_bad <= par_acc ^ sin;
            state   <= StStop;
          end
`endif

          StStop: begin
            state <= StIdle;
            busy  <= 1'b0;
            if (!sin) begin
              frame_err <= 1'b1;
            end
`ifdef SIPO_PARITY_EN
            if (par_bad) begin
              parity_err <= 1'b1;
            end
`endif
            if (word_good) begin
              if (hold_free) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end

          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver (WIDTH=4, default build without parity).
module tb_sipo_frame_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       msb_first;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo_frame_receiver #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .msb_first  (msb_first),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  // seq is listed in send order, left to right: start, d0..d3 as sent, stop.
  typedef struct {
    logic       msb;
    logic [5:0] seq;
    logic [3:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin       = 1'b1;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    sin       = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [5:0] seq);
    for (int i = 0; i < 6; i++) strobe(seq[5-i]);
  endtask

  task automatic drain;
    data_ready = 1'b1;
    idle(1);
    data_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{msb: 1'b0, seq: 6'b010111, exp_data: 4'b1101, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{msb: 1'b1, seq: 6'b010111, exp_data: 4'b1011, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{msb: 1'b0, seq: 6'b011110, exp_data: 4'b1011, exp_valid: 1'b0, exp_ferr: 1'b1};
    vecs[3] = '{msb: 1'b0, seq: 6'b001011, exp_data: 4'hA,    exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{msb: 1'b1, seq: 6'b001011, exp_data: 4'h5,    exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{msb: 1'b0, seq: 6'b011111, exp_data: 4'hF,    exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[6] = '{msb: 1'b1, seq: 6'b010001, exp_data: 4'h8,    exp_valid: 1'b1, exp_ferr: 1'b0};

    rst        = 1'b1;
    sin        = 1'b1;
    sin_valid  = 1'b0;
    msb_first  = 1'b0;
    data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset data_out", 32'(data_out), 32'h0);
    check("reset data_valid", 32'(data_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);

    // Idle-line strobes must not start a frame.
    repeat (3) strobe(1'b1);
    check("idle ones busy", 32'(busy), 32'h0);

    // Table-driven frames with continuous strobes.
    for (int k = 0; k < 7; k++) begin
      drain();
      msb_first = vecs[k].msb;
      for (int i = 0; i < 6; i++) begin
        strobe(vecs[k].seq[5-i]);
        check($sformatf("v%0d busy after bit %0d", k, i), 32'(busy), (i < 5) ? 32'h1 : 32'h0);
      end
      check($sformatf("v%0d data_valid", k), 32'(data_valid), 32'(vecs[k].exp_valid));
      check($sformatf("v%0d data_out", k), 32'(data_out), 32'(vecs[k].exp_data));
      check($sformatf("v%0d frame_err", k), 32'(frame_err), 32'(vecs[k].exp_ferr));
      idle(1);
      check($sformatf("v%0d frame_err pulse end", k), 32'(frame_err), 32'h0);
      check($sformatf("v%0d overrun", k), 32'(overrun), 32'h0);
    end

    // msb_first toggled mid-frame: direction latched at start stays MSB-first.
    drain();
    msb_first = 1'b1;
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b0);
    msb_first = 1'b0;
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b1);
    check("toggle data_valid", 32'(data_valid), 32'h1);
    check("toggle data_out", 32'(data_out), 32'h3);

    // Strobe gaps with junk on sin must be ignored.
    drain();
    msb_first = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [5:0] s;
      s = 6'b010111;
      strobe(s[5-i]);
      sin       = 1'b0;
      sin_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (i == 2) check("gap busy mid", 32'(busy), 32'h1);
    end
    check("gap data_valid", 32'(data_valid), 32'h1);
    check("gap data_out", 32'(data_out), 32'hD);
    check("gap busy end", 32'(busy), 32'h0);

    // Back-to-back frames with a full holding register: second word dropped.
    drain();
    send_frame(6'b001011);
    check("ovr first valid", 32'(data_valid), 32'h1);
    check("ovr first data", 32'(data_out), 32'hA);
    check("ovr first overrun", 32'(overrun), 32'h0);
    send_frame(6'b010101);
    check("ovr kept data", 32'(data_out), 32'hA);
    check("ovr valid", 32'(data_valid), 32'h1);
    check("ovr set", 32'(overrun), 32'h1);
    data_ready = 1'b1;
    idle(1);
    data_ready = 1'b0;
    check("ovr drained valid", 32'(data_valid), 32'h0);
    check("ovr sticky after drain", 32'(overrun), 32'h1);
    send_frame(6'b011111);
    check("ovr later data", 32'(data_out), 32'hF);
    check("ovr sticky later", 32'(overrun), 32'h1);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst clears overrun", 32'(overrun), 32'h0);
    check("rst clears valid", 32'(data_valid), 32'h0);

    // data_ready in the same cycle as the second stop strobe: no overrun.
    send_frame(6'b001011);
    for (int i = 0; i < 5; i++) begin
      logic [5:0] s;
      s = 6'b010101;
      strobe(s[5-i]);
    end
    data_ready = 1'b1;
    strobe(1'b1);
    data_ready = 1'b0;
    check("same-cycle data_out", 32'(data_out), 32'h5);
    check("same-cycle valid", 32'(data_valid), 32'h1);
    check("same-cycle overrun", 32'(overrun), 32'h0);

    // Reset after two data bits, with a start bit presented in the reset cycle.
    drain();
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    check("pre-rst busy", 32'(busy), 32'h1);
    rst       = 1'b1;
    sin       = 1'b0;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    sin_valid = 1'b0;
    sin       = 1'b1;
    check("mid rst busy", 32'(busy), 32'h0);
    check("mid rst data_out", 32'(data_out), 32'h0);
    check("mid rst valid", 32'(data_valid), 32'h0);
    check("mid rst frame_err", 32'(frame_err), 32'h0);
    check("mid rst overrun", 32'(overrun), 32'h0);
    send_frame(6'b001101);
    check("post rst valid", 32'(data_valid), 32'h1);
    check("post rst data_out", 32'(data_out), 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
